launch_ctrl: RTL and testbench
==============================

// Module: launch_ctrl
// PURPOSE
//  Dual-issue launch scheduler between the fetch/decode instruction queue and the issue stage. Each
//  cycle it checks the two queue-head instructions and raises exactly one of double/single/zero
//  launch. Those three flags drive the queue tail pointer and the issue-stage capture.
//  It resolves intra-pair hazards, load-use hazards (per-register scoreboard) and serialising
//  instructions (CSR/barrier/ertn) with a small FSM.
// PARAMETERS
//  DOUBLE_LAUNCH   1   0: line2 never launches (single-issue build)
//  LOAD_USE_STALL  2   cycles a launched load's rd stays busy (1..3; 2-bit counter)
// PORTS
//  clk                               in   1   clock
//  rst_n                             in   1   async reset, active low
//  line1_valid_i / line2_valid_i     in   1   queue-head slot valid (line2 valid only with line1 valid)
//  line1_rd_i / line2_rd_i           in   5   destination register
//  line1_src_i / line2_src_i         in   10  {rk[9:5], rj[4:0]}
//  line1_ctl_i / line2_ctl_i         in   7   {serial, branch, mem, load, rk_re, rj_re, rd_we}
//  next_allowin_i                    in   1   issue stage can accept this cycle
//  backend_idle_i                    in   1   EXE/MEM/WB hold no valid instruction
//  branch_flush_i / excep_flush_i    in   1   pipeline flush
//  double_valid_inst_lunch_flag_o    out  1   launch line1+line2
//  single_valid_inst_lunch_flag_o    out  1   launch line1 only
//  zero_valid_inst_lunch_flag_o      out  1   launch nothing
//  serial_busy_o                     out  1   FSM in SER_WAIT or SER_DRAIN
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, all scoreboard counters=0. Flags decode to zero launch; serial_busy_o=0.
//  Flags: combinational, one-hot, same cycle as inputs. zero=1 when neither of the others is asserted.
//  Flag/state/scoreboard effects take effect at the next posedge.
//  busy(r): sb_cnt[r]!=0 && r!=0. src_ok(L) = !(rj_re && busy(rj)) && !(rk_re && busy(rk)).
//  can1 = line1_valid && next_allowin_i && src_ok(1) && no flush && state==RUN
//         && (!serial1 || backend_idle_i).
//  can2 = can1 && DOUBLE_LAUNCH && line2_valid && src_ok(2) && !serial1 && !serial2 && !branch1
//         && !(mem1 && mem2) && !RAW && !(rd_we1 && rd_we2 && rd1==rd2).
//  RAW: rd_we1, rd1!=0, and rd1 matches an enabled line2 source (rj_re/rj or rk_re/rk).
//  double=can2; single=can1&&!can2.
//  FSM (2-bit): RUN=0, SER_WAIT=1, SER_DRAIN=2, FLUSH=3.
//   RUN: line1_valid && serial1 && next_allowin_i && src_ok(1) && !backend_idle_i -> SER_WAIT.
//        Also in RUN: single launch of a serial -> SER_DRAIN.
//   SER_WAIT: zero launch; backend_idle_i -> RUN (serial launches the following cycle).
//   SER_DRAIN: zero launch; backend_idle_i -> RUN.
//   FLUSH: zero launch for exactly one cycle -> RUN.
//   Any state: branch_flush_i|excep_flush_i -> FLUSH, highest priority. Flush cycle itself is zero launch.
//  Scoreboard: 32 x 2-bit counters. Launched load with rd_we && rd!=0 sets sb_cnt[rd]=LOAD_USE_STALL.
//   This covers line1 on single/double launch and line2 on double launch.
//   Other nonzero counters decrement by 1. Set beats decrement on the same reg.
//   Flush clears all counters. r0 is never busy.
//  Line1 blocked => line2 never launches (in-order). Flags never assert double when DOUBLE_LAUNCH=0.
// TESTING
//  1 Independent add pair, next_allowin=1 -> double=1 every cycle; next_allowin=0 -> zero=1.
//  2 line1 add r4, line2 sub reads r4 -> single=1; with rd=r0 instead -> double=1.
//  3 load r5 launched, next pair reads r5 -> zero for 2 cycles (LOAD_USE_STALL=2), single/double on 3rd.
//  4 line1 csrwr, backend_idle=0 -> SER_WAIT, zero. Idle=1 -> RUN, then single, SER_DRAIN.
//    SER_DRAIN until idle; serial_busy_o tracks the FSM.
//  5 Flush during SER_DRAIN with busy r7 -> FLUSH 1 cycle zero, sb cleared, then RUN double launch.
//  6 rst_n low mid-SER_WAIT -> immediate zero=1, serial_busy_o=0, state RUN after release.

Source files
------------

// File: rtl/launch_ctrl.sv
// -----------------------------------------------------------------------------
// launch_ctrl
//   Dual-issue launch scheduler between the instruction queue and the issue
//   stage. Each cycle it looks at the two queue-head instructions and raises
//   exactly one of double / single / zero launch. Those flags move the queue
//   tail pointer and tell the issue stage what to capture.
//
//   It resolves:
//     - intra-pair hazards (RAW, WAW, two memory ops, branch/serial in line1)
//     - load-use hazards through a per-register countdown scoreboard
//     - serialising instructions (CSR / barrier / ertn) through a small FSM
//
// Parameters
//   DOUBLE_LAUNCH   0 => line2 never launches (single-issue build)
//   LOAD_USE_STALL  cycles a launched load's rd stays busy (1..3)
//
// Ports
//   clk, rst_n                          clock, async active-low reset
//   line{1,2}_valid_i                   queue-head slot valid
//   line{1,2}_rd_i        [4:0]         destination register
//   line{1,2}_src_i       [9:0]         {rk, rj}
//   line{1,2}_ctl_i       [6:0]         {serial, branch, mem, load, rk_re, rj_re, rd_we}
//   next_allowin_i                      issue stage can accept this cycle
//   backend_idle_i                      EXE/MEM/WB hold no valid instruction
//   branch_flush_i, excep_flush_i       pipeline flush
//   double/single/zero_valid_inst_lunch_flag_o   one-hot launch decision
//   serial_busy_o                       serialisation in progress
// -----------------------------------------------------------------------------
module launch_ctrl #(
  parameter bit          DOUBLE_LAUNCH  = 1'b1,
  parameter int unsigned LOAD_USE_STALL = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line1_valid_i,
  input  logic       line2_valid_i,
  input  logic [4:0] line1_rd_i,
  input  logic [4:0] line2_rd_i,
  input  logic [9:0] line1_src_i,
  input  logic [9:0] line2_src_i,
  input  logic [6:0] line1_ctl_i,
  input  logic [6:0] line2_ctl_i,
  input  logic       next_allowin_i,
  input  logic       backend_idle_i,
  input  logic       branch_flush_i,
  input  logic       excep_flush_i,
  output logic       double_valid_inst_lunch_flag_o,
  output logic       single_valid_inst_lunch_flag_o,
  output logic       zero_valid_inst_lunch_flag_o,
  output logic       serial_busy_o
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SER_WAIT  = 2'd1,
    SER_DRAIN = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  typedef struct packed {
    logic serial;
    logic branch;
    logic mem;
    logic load;
    logic rk_re;
    logic rj_re;
    logic rd_we;
  } ctl_t;

  localparam logic [1:0] STALL_CNT = 2'(LOAD_USE_STALL);

  state_t     state_q, state_d;
  logic [1:0] sb_cnt [32];
  logic [31:0] busy_vec;

  ctl_t       l1, l2;
  logic [4:0] rj1, rk1, rj2, rk2;
  logic       flush;
  logic       src_ok1, src_ok2;
  logic       raw, waw;
  logic       can1, can2;
  logic       set1, set2;

  assign l1    = ctl_t'(line1_ctl_i);
  assign l2    = ctl_t'(line2_ctl_i);
  assign rj1   = line1_src_i[4:0];
  assign rk1   = line1_src_i[9:5];
  assign rj2   = line2_src_i[4:0];
  assign rk2   = line2_src_i[9:5];
  assign flush = branch_flush_i | excep_flush_i;

  // A branch in line2 does not restrict pairing.
  logic unused_bits;
  assign unused_bits = l2.branch;

  // r0 is hard-wired zero and therefore never busy.
  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) begin
      busy_vec[i] = (sb_cnt[i] != 2'd0);
    end
  end

  assign src_ok1 = !(l1.rj_re && busy_vec[rj1]) && !(l1.rk_re && busy_vec[rk1]);
  assign src_ok2 = !(l2.rj_re && busy_vec[rj2]) && !(l2.rk_re && busy_vec[rk2]);

  assign raw = l1.rd_we && (line1_rd_i != 5'd0) &&
               ((l2.rj_re && (rj2 == line1_rd_i)) || (l2.rk_re && (rk2 == line1_rd_i)));
  assign waw = l1.rd_we && l2.rd_we && (line1_rd_i == line2_rd_i);

  // Reset is folded in so the flags read "zero launch" while rst_n is low,
  // even with valid instructions presented at the queue head.
  assign can1 = rst_n && line1_valid_i && next_allowin_i && src_ok1 && !flush &&
                (state_q == RUN) && (!l1.serial || backend_idle_i);

  // Line2 may only launch alongside line1, which keeps issue in order.
  assign can2 = can1 && DOUBLE_LAUNCH && line2_valid_i && src_ok2 &&
                !l1.serial && !l2.serial && !l1.branch && !(l1.mem && l2.mem) &&
                !raw && !waw;

  assign double_valid_inst_lunch_flag_o = can2;
  assign single_valid_inst_lunch_flag_o = can1 && !can2;
  assign zero_valid_inst_lunch_flag_o   = !can1;
  assign serial_busy_o = (state_q == SER_WAIT) || (state_q == SER_DRAIN);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        // A serial instruction must see an empty backend before launching;
        // once it launches we wait for it to drain before resuming.
        if (line1_valid_i && l1.serial && next_allowin_i && src_ok1 && !backend_idle_i)
          state_d = SER_WAIT;
        else if (can1 && l1.serial)
          state_d = SER_DRAIN;
      end
      SER_WAIT:  if (backend_idle_i) state_d = RUN;
      SER_DRAIN: if (backend_idle_i) state_d = RUN;
      FLUSH:     state_d = RUN;
      default:   state_d = RUN;
    endcase
    if (flush) state_d = FLUSH;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign set1 = can1 && l1.load && l1.rd_we && (line1_rd_i != 5'd0);
  assign set2 = can2 && l2.load && l2.rd_we && (line2_rd_i != 5'd0);

  // NOTE: the scoreboard is a small flop array whose contents gate launches,
  // so it must be reset; a stale count would stall or mis-issue after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) sb_cnt[i] <= 2'd0;
    end else if (flush) begin
      // Squashed loads will never write back, so their hazards vanish.
      for (int i = 0; i < 32; i++) sb_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if ((set1 && (line1_rd_i == 5'(i))) || (set2 && (line2_rd_i == 5'(i))))
          sb_cnt[i] <= STALL_CNT;
        else if (sb_cnt[i] != 2'd0)
          sb_cnt[i] <= sb_cnt[i] - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_launch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_launch_ctrl
//   Directed scenarios followed by randomized traffic, all compared against a
//   behavioural model: register readiness is tracked as "cycle number when the
//   register becomes readable", and serialisation as a few boolean modes.
// -----------------------------------------------------------------------------
module tb_launch_ctrl;

  localparam bit DL    = 1'b1;
  localparam int STALL = 2;

  // ctl = {serial, branch, mem, load, rk_re, rj_re, rd_we}
  localparam logic [6:0] C_ADD = 7'b0000111;
  localparam logic [6:0] C_LD  = 7'b0011011;
  localparam logic [6:0] C_CSR = 7'b1000011;
  localparam logic [6:0] C_NOP = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v1, v2;
  logic [4:0] rd1, rd2;
  logic [9:0] src1, src2;
  logic [6:0] ctl1, ctl2;
  logic       na, idle, bflush, eflush;
  logic       o_dbl, o_sgl, o_zero, o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  launch_ctrl #(.DOUBLE_LAUNCH(DL), .LOAD_USE_STALL(STALL)) dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .line1_valid_i                  (v1),
    .line2_valid_i                  (v2),
    .line1_rd_i                     (rd1),
    .line2_rd_i                     (rd2),
    .line1_src_i                    (src1),
    .line2_src_i                    (src2),
    .line1_ctl_i                    (ctl1),
    .line2_ctl_i                    (ctl2),
    .next_allowin_i                 (na),
    .backend_idle_i                 (idle),
    .branch_flush_i                 (bflush),
    .excep_flush_i                  (eflush),
    .double_valid_inst_lunch_flag_o (o_dbl),
    .single_valid_inst_lunch_flag_o (o_sgl),
    .zero_valid_inst_lunch_flag_o   (o_zero),
    .serial_busy_o                  (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0;
  int ready_at [32];          // register readable from this cycle number on
  bit m_wait, m_drain, m_flush;
  bit e_c1, e_c2;

  function automatic bit reg_busy(input logic [4:0] r);
    return (r != 0) && (cyc < ready_at[r]);
  endfunction

  function automatic bit srcs_ready(input logic [9:0] s, input logic [6:0] c);
    return !(c[1] && reg_busy(s[4:0])) && !(c[2] && reg_busy(s[9:5]));
  endfunction

  function automatic bit reads_reg(input logic [9:0] s, input logic [6:0] c, input logic [4:0] r);
    return (c[1] && s[4:0] == r) || (c[2] && s[9:5] == r);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    m_wait = 0; m_drain = 0; m_flush = 0;
  endtask

  task automatic model_eval();
    bit fl, running, pair_ok;
    fl      = bflush || eflush;
    running = !m_wait && !m_drain && !m_flush;
    e_c1 = rst_n && v1 && na && srcs_ready(src1, ctl1) && !fl && running && (!ctl1[6] || idle);
    pair_ok = v2 && srcs_ready(src2, ctl2) && !ctl1[6] && !ctl2[6] && !ctl1[5] &&
              !(ctl1[4] && ctl2[4]) &&
              !(ctl1[0] && rd1 != 0 && reads_reg(src2, ctl2, rd1)) &&
              !(ctl1[0] && ctl2[0] && rd1 == rd2);
    e_c2 = e_c1 && DL && pair_ok;
  endtask

  task automatic model_step();
    bit running;
    running = !m_wait && !m_drain && !m_flush;
    if (!rst_n) begin
      model_reset();
    end else if (bflush || eflush) begin
      for (int i = 0; i < 32; i++) ready_at[i] = 0;
      m_flush = 1; m_wait = 0; m_drain = 0;
    end else begin
      if (m_flush) m_flush = 0;
      if (m_wait && idle) m_wait = 0;
      if (m_drain && idle) m_drain = 0;
      if (running) begin
        if (v1 && ctl1[6] && na && srcs_ready(src1, ctl1) && !idle) m_wait = 1;
        else if (e_c1 && ctl1[6]) m_drain = 1;
      end
      if (e_c1 && ctl1[3] && ctl1[0] && rd1 != 0) ready_at[rd1] = cyc + 1 + STALL;
      if (e_c2 && ctl2[3] && ctl2[0] && rd2 != 0) ready_at[rd2] = cyc + 1 + STALL;
    end
    cyc++;
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic cycle(input string tag);
    #1;
    model_eval();
    check({tag, ".flags"}, {29'd0, o_dbl, o_sgl, o_zero},
          {29'd0, e_c2, e_c1 && !e_c2, !e_c1});
    check({tag, ".busy"}, {31'd0, o_busy}, {31'd0, m_wait || m_drain});
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  function automatic logic [9:0] srcs(input logic [4:0] rk, input logic [4:0] rj);
    return {rk, rj};
  endfunction

  task automatic set_l1(input logic v, input logic [4:0] rd, input logic [9:0] s, input logic [6:0] c);
    v1 = v; rd1 = rd; src1 = s; ctl1 = c;
  endtask

  task automatic set_l2(input logic v, input logic [4:0] rd, input logic [9:0] s, input logic [6:0] c);
    v2 = v; rd2 = rd; src2 = s; ctl2 = c;
  endtask

  initial begin
    rst_n = 1'b0; na = 1'b0; idle = 1'b1; bflush = 1'b0; eflush = 1'b0;
    set_l1(1'b1, 5'd1, srcs(5'd2, 5'd3), C_ADD);
    set_l2(1'b1, 5'd4, srcs(5'd5, 5'd6), C_ADD);
    na = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    // Valid pair presented during reset must still decode to zero launch.
    check("reset.flags", {29'd0, o_dbl, o_sgl, o_zero}, 32'd1);
    check("reset.busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: independent adds, then back-pressure
    repeat (3) cycle("t1.pair");
    na = 1'b0;
    cycle("t1.noallow");
    na = 1'b1;

    // 2: intra-pair RAW, then same pair with line1 writing r0
    set_l1(1'b1, 5'd4, srcs(5'd2, 5'd3), C_ADD);
    set_l2(1'b1, 5'd9, srcs(5'd4, 5'd6), C_ADD);
    cycle("t2.raw");
    rd1 = 5'd0;
    cycle("t2.r0");

    // 3: load r5 then consumers of r5
    set_l1(1'b1, 5'd5, srcs(5'd0, 5'd1), C_LD);
    set_l2(1'b0, 5'd0, 10'd0, C_NOP);
    cycle("t3.load");
    set_l1(1'b1, 5'd8, srcs(5'd1, 5'd5), C_ADD);
    set_l2(1'b1, 5'd9, srcs(5'd2, 5'd3), C_ADD);
    repeat (3) cycle("t3.use");

    // 4: csr with busy backend, then drain
    set_l1(1'b1, 5'd10, srcs(5'd0, 5'd1), C_CSR);
    idle = 1'b0;
    repeat (2) cycle("t4.wait");
    idle = 1'b1;
    cycle("t4.release");
    cycle("t4.launch");
    set_l1(1'b1, 5'd11, srcs(5'd2, 5'd3), C_ADD);
    idle = 1'b0;
    repeat (2) cycle("t4.drain");
    idle = 1'b1;
    repeat (2) cycle("t4.resume");

    // 5: flush during drain with r7 pending
    set_l1(1'b1, 5'd7, srcs(5'd0, 5'd1), C_LD);
    set_l2(1'b0, 5'd0, 10'd0, C_NOP);
    cycle("t5.load");
    set_l1(1'b1, 5'd12, srcs(5'd0, 5'd1), C_CSR);
    cycle("t5.csr");
    set_l1(1'b1, 5'd13, srcs(5'd2, 5'd7), C_ADD);
    set_l2(1'b1, 5'd14, srcs(5'd7, 5'd3), C_ADD);
    idle = 1'b0; eflush = 1'b1;
    cycle("t5.flush");
    eflush = 1'b0; idle = 1'b1;
    cycle("t5.flushst");
    cycle("t5.after");

    // 6: reset in SER_WAIT
    set_l1(1'b1, 5'd10, srcs(5'd0, 5'd1), C_CSR);
    set_l2(1'b0, 5'd0, 10'd0, C_NOP);
    idle = 1'b0;
    repeat (2) cycle("t6.wait");
    rst_n = 1'b0;
    #1;
    check("t6.rst.flags", {29'd0, o_dbl, o_sgl, o_zero}, 32'd1);
    check("t6.rst.busy", {31'd0, o_busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle = 1'b1;
    cycle("t6.after");

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      v1 = ($urandom_range(0, 99) < 85);
      v2 = v1 && ($urandom_range(0, 99) < 75);
      rd1 = 5'($urandom_range(0, 7));
      rd2 = 5'($urandom_range(0, 7));
      src1 = srcs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      src2 = srcs(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ctl1 = 7'($urandom);
      ctl2 = 7'($urandom);
      ctl1[6] = ($urandom_range(0, 9) == 0);
      ctl2[6] = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 1) ctl1[3] = 1'b1;
      na     = ($urandom_range(0, 99) < 80);
      idle   = ($urandom_range(0, 1) == 1);
      bflush = ($urandom_range(0, 39) == 0);
      eflush = ($urandom_range(0, 59) == 0);
      cycle("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
